// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-coded output and wrap pulse.
// Optional registered binary output bin_out when GRAY_CNT_BIN_OUT_EN is defined.
module gray_counter #(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray_out,
`ifdef GRAY_CNT_BIN_OUT_EN
   output logic             wrap,
   output logic [WIDTH-1:0] bin_out
`else
   output logic             wrap
`endif
);

   localparam bit SAT = (SATURATE != 0);

   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] step_bin;
   logic             end_hit;
   logic             wrap_nxt;

   // Gray -> binary conversion of the load value, MSB first
   always_comb begin
      load_bin = '0;
      load_bin[WIDTH-1] = load_val[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         load_bin[i] = load_bin[i+1] ^ load_val[i];
      end
   end

   assign step_bin = up ? bin + WIDTH'(1) : bin - WIDTH'(1);
   assign end_hit  = up ? (&bin) : ~(|bin);

   // Next binary state and wrap; load beats en, saturation holds at the ends
   always_comb begin
      bin_nxt  = bin;
      wrap_nxt = 1'b0;
      if (load) begin
         bin_nxt = load_bin;
      end else if (en) begin
         if (end_hit && SAT) begin
            bin_nxt = bin;
         end else begin
            bin_nxt  = step_bin;
            wrap_nxt = end_hit;
         end
      end
   end

   // State, Gray output and wrap pulse all registered together
   always_ff @(posedge clk) begin
      if (rst) begin
         bin      <= '0;
         gray_out <= '0;
         wrap     <= 1'b0;
      end else begin
         bin      <= bin_nxt;
         gray_out <= bin_nxt ^ (bin_nxt >> 1);
         wrap     <= wrap_nxt;
      end
   end

`ifdef GRAY_CNT_BIN_OUT_EN
   assign bin_out = bin;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: wrapping and saturating instances.
// Hand-computed Gray sequences, wrap pulses, load, reset and saturation.
module tb_gray_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_en, a_up, a_load, a_wrap;
   logic [3:0] a_lv, a_gray;
   logic       s_rst, s_en, s_up, s_load, s_wrap;
   logic [3:0] s_lv, s_gray;
`ifdef GRAY_CNT_BIN_OUT_EN
   logic [3:0] a_bin, s_bin;
`endif

   gray_counter #(.WIDTH(4), .SATURATE(0)) u_dut (
      .clk(clk), .rst(a_rst), .en(a_en), .up(a_up),
      .load(a_load), .load_val(a_lv), .gray_out(a_gray),
`ifdef GRAY_CNT_BIN_OUT_EN
      .wrap(a_wrap), .bin_out(a_bin)
`else
      .wrap(a_wrap)
`endif
   );

   gray_counter #(.WIDTH(4), .SATURATE(1)) u_sat (
      .clk(clk), .rst(s_rst), .en(s_en), .up(s_up),
      .load(s_load), .load_val(s_lv), .gray_out(s_gray),
`ifdef GRAY_CNT_BIN_OUT_EN
      .wrap(s_wrap), .bin_out(s_bin)
`else
      .wrap(s_wrap)
`endif
   );

   // Gray codes of binary 0..15, written out by hand
   localparam logic [3:0] GSEQ [16] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110,
      4'b1010, 4'b1011, 4'b1001, 4'b1000
   };

   int nvec = 0;
   int nerr = 0;
   logic [3:0] prev;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_rst = 1; a_en = 0; a_up = 1; a_load = 0; a_lv = '0;
      s_rst = 1; s_en = 0; s_up = 1; s_load = 0; s_lv = '0;
      step(); step();
      chk("rst_gray", 8'(a_gray), 8'h0);
      chk("rst_wrap", 8'(a_wrap), 8'h0);
      a_rst = 0; s_rst = 0;
      step(); step();
      chk("hold_gray", 8'(a_gray), 8'h0);
      chk("hold_wrap", 8'(a_wrap), 8'h0);

      // count up 15 steps, each a single-bit change
      a_en = 1; a_up = 1;
      for (int k = 1; k <= 15; k++) begin
         prev = a_gray;
         step();
         chk($sformatf("up%0d", k), 8'(a_gray), 8'(GSEQ[k]));
         chk($sformatf("up%0d_1bit", k),
             8'($countones(prev ^ a_gray)), 8'd1);
         chk($sformatf("up%0d_wrap", k), 8'(a_wrap), 8'h0);
`ifdef GRAY_CNT_BIN_OUT_EN
         chk($sformatf("up%0d_bin", k), 8'(a_bin), 8'(k));
`endif
      end
      chk("up5_check", 8'(GSEQ[5]), 8'h07);

      // wrap up 1000 -> 0000
      prev = a_gray;
      step();
      chk("wrapup_gray", 8'(a_gray), 8'h0);
      chk("wrapup_wrap", 8'(a_wrap), 8'h1);
      chk("wrapup_1bit", 8'($countones(prev ^ a_gray)), 8'd1);
      a_en = 0;
      step();
      chk("wrapup_clr", 8'(a_wrap), 8'h0);
      chk("wrapup_hold", 8'(a_gray), 8'h0);

      // wrap down 0000 -> 1000
      a_en = 1; a_up = 0;
      step();
      chk("wrapdn_gray", 8'(a_gray), 8'h8);
      chk("wrapdn_wrap", 8'(a_wrap), 8'h1);
      a_en = 0;
      step();
      chk("wrapdn_clr", 8'(a_wrap), 8'h0);

      // load 1100 (bin 8) with en high; then step up
      a_load = 1; a_lv = 4'b1100; a_en = 1; a_up = 1;
      step();
      chk("load_gray", 8'(a_gray), 8'hC);
      chk("load_wrap", 8'(a_wrap), 8'h0);
`ifdef GRAY_CNT_BIN_OUT_EN
      chk("load_bin", 8'(a_bin), 8'd8);
`endif
      a_load = 0;
      step();
      chk("afterload", 8'(a_gray), 8'hD);
`ifdef GRAY_CNT_BIN_OUT_EN
      chk("afterload_bin", 8'(a_bin), 8'd9);
`endif
      // immediate direction change
      a_up = 0;
      step();
      chk("dirchg", 8'(a_gray), 8'hC);

      // reset mid-count at 0101 (bin 6)
      a_load = 1; a_lv = 4'b0101;
      step();
      chk("ld0101", 8'(a_gray), 8'h5);
      a_load = 0; a_rst = 1; a_en = 1; a_up = 1;
      step();
      chk("midrst_gray", 8'(a_gray), 8'h0);
      a_rst = 0;
      step();
      chk("resume", 8'(a_gray), 8'h1);

      // reset on the edge that would have wrapped
      a_load = 1; a_lv = 4'b1000;
      step();
      a_load = 0; a_rst = 1;
      step();
      chk("rstwrap_gray", 8'(a_gray), 8'h0);
      chk("rstwrap_wrap", 8'(a_wrap), 8'h0);
      a_rst = 0; a_en = 0;

      // saturating instance: climb to 1000 then push 3 more
      s_en = 1; s_up = 1;
      for (int k = 0; k < 15; k++) step();
      chk("sat_top", 8'(s_gray), 8'h8);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("sat_hold%0d", k), 8'(s_gray), 8'h8);
         chk($sformatf("sat_wrap%0d", k), 8'(s_wrap), 8'h0);
      end
      s_up = 0;
      step();
      chk("sat_down", 8'(s_gray), 8'h9);
`ifdef GRAY_CNT_BIN_OUT_EN
      chk("sat_down_bin", 8'(s_bin), 8'd14);
`endif
      s_load = 1; s_lv = 4'b0000;
      step();
      s_load = 0;
      step();
      chk("sat_bot", 8'(s_gray), 8'h0);
      chk("sat_bot_wrap", 8'(s_wrap), 8'h0);
      s_up = 1;
      step();
      chk("sat_away", 8'(s_gray), 8'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
